uart_tx_frame_engine: RTL and testbench
=======================================

// Module: uart_tx_frame_engine
// PURPOSE
//   Parametrised UART transmit engine: accepts a parallel word, serialises it LSB-first
//   as start / DATA_WIDTH data / optional parity / 1-or-2 stop bits. Paced by an external
//   bit-rate tick. Registered line output, no glitches. Sits in the UART TX clock domain
//   and drives the serial line directly; replaces the fixed 8-bit frame path.
// PARAMETERS
//   DATA_WIDTH  8  data bits per frame, legal range 5..9
//   IDLE_LEVEL  1  line level in idle and stop bits. The start bit is ~IDLE_LEVEL.
// PORTS
//   CLK         in   1           single clock
//   RST         in   1           synchronous reset, active-high
//   BIT_TICK    in   1           1-cycle pulse; ends the current bit period
//   P_DATA      in   DATA_WIDTH  word to transmit
//   DATA_VALID  in   1           request; accepted only when BUSY=0 (or at frame end, see below)
//   PAR_EN      in   1           1: insert parity bit
//   PAR_TYP     in   1           0: even, 1: odd
//   STOP2       in   1           1: two stop bits, 0: one
//   TX_OUT      out  1           serial line (registered)
//   BUSY        out  1           high from accept+1 until the last stop bit ends
//   DATA_ACK    out  1           1-cycle pulse in the cycle after a word is accepted
// BEHAVIOUR
//   Reset, RST=1 at a CLK edge:
//     - state=IDLE; TX_OUT=IDLE_LEVEL; BUSY=0; DATA_ACK=0; bit counter=0.
//     - Reset mid-frame aborts the frame immediately. TX_OUT returns to the idle level next cycle.
//   Accept:
//     - state=IDLE and DATA_VALID=1 latches P_DATA, PAR_EN, PAR_TYP, STOP2 into shadow regs.
//     - Inputs are don't-care after accept. Next cycle: state=START, TX_OUT=~IDLE_LEVEL,
//       BUSY=1, DATA_ACK=1.
//   Bit timing:
//     - Each bit is held on TX_OUT until a cycle with BIT_TICK=1. The next bit appears the
//       following cycle.
//     - BIT_TICK while IDLE is ignored.
//   States and transitions (each transition is on BIT_TICK):
//     - IDLE   -> START  on accept (no tick needed)
//     - START  -> DATA
//     - DATA   -> DATA while bit_cnt < DATA_WIDTH-1. Bit bit_cnt is sent LSB-first,
//                 bit_cnt increments.
//     - DATA   -> PARITY if PAR_EN_q, else -> STOP
//     - PARITY -> STOP. Parity = ^data_q ^ PAR_TYP_q (even: XOR, odd: XNOR).
//     - STOP   -> STOP2 if STOP2_q, else end-of-frame
//     - STOP2  -> end-of-frame
//   End-of-frame:
//     - If DATA_VALID=1 in the ending-tick cycle, the new word is accepted. Next cycle goes
//       straight to START with BUSY held 1 and DATA_ACK pulsing (back-to-back, no idle bit).
//     - Otherwise next cycle: IDLE, BUSY=0.
//   Ignored inputs: DATA_VALID during BUSY, except in the end-of-frame tick. It is neither
//     queued nor acknowledged.
//   bit_cnt: $clog2(DATA_WIDTH) bits wide. Cleared on entry to DATA. Never wraps within a frame.
//   Frame length: 1 + DATA_WIDTH + PAR_EN + (1+STOP2) ticks.
// STRUCTURE
//   Package uart_tx_pkg:
//     - State encoding localparams: IDLE, START, DATA, PARITY, STOP, STOP2.
//     - Line-select encoding: SEL_START=2'b00, SEL_DATA=2'b01, SEL_PAR=2'b10, SEL_STOP=2'b11.
//   Sub-module uart_tx_line_sel:
//     - Registered 4:1 select of {start, data bit, parity, stop} by sel code.
//     - Reset value IDLE_LEVEL. Full case with default = IDLE_LEVEL.
//   Top level: FSM, bit counter, shadow registers, parity generator.
// TESTING
//   1. 8N1 frame: P_DATA=8'hA5, PAR_EN=0, STOP2=0, tick every 16 cycles
//      -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 per tick (10 ticks); BUSY falls after the 10th tick.
//   2. Parity: 8'hA5 with even parity -> parity bit 0; odd parity -> 1.
//      8'h07 even -> 1. Frame = 11 ticks.
//   3. DATA_WIDTH=9 build, STOP2=1, P_DATA=9'h1FF
//      -> 9 ones, then 2 stop bits of 1; total 12 ticks.
//   4. Back-to-back: DATA_VALID held high with 8'h55 then 8'h0F
//      -> second start bit immediately follows the stop bit; BUSY never drops;
//         exactly 2 DATA_ACK pulses.
//   5. DATA_VALID pulsed mid-frame, P_DATA changed mid-frame
//      -> no extra DATA_ACK; transmitted word is unchanged.
//   6. RST asserted during data bit 3
//      -> next cycle TX_OUT=1, BUSY=0. A new accept afterwards transmits a clean frame.

Source files
------------

// File: rtl/uart_tx_frame_engine_pkg.sv
// Shared types and constants for the UART transmit frame engine.
package uart_tx_pkg;

    // Widest data word any build of the engine supports.
    localparam int MAX_DATA_WIDTH = 9;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    // Line-select codes for the registered output mux.
    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_DATA  = 2'b01;
    localparam logic [1:0] SEL_PAR   = 2'b10;
    localparam logic [1:0] SEL_STOP  = 2'b11;

    // Parity over a zero-extended word; zero padding does not change the XOR.
    // odd=0 gives even parity, odd=1 gives odd parity.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_frame_engine_if.sv
// Request/line bundle between a word producer and the UART transmit engine.
interface uart_tx_frame_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  BIT_TICK;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic                  TX_OUT;
    logic                  BUSY;
    logic                  DATA_ACK;

    // Producer side: supplies words, frame options and bit pacing.
    modport master (
        output BIT_TICK, P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
        input  TX_OUT, BUSY, DATA_ACK
    );

    // Engine side: consumes requests, drives the serial line and status.
    modport slave (
        input  BIT_TICK, P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
        output TX_OUT, BUSY, DATA_ACK
    );
endinterface

// File: rtl/uart_tx_frame_engine_line_sel.sv
// Registered 4:1 line driver: start, data bit, parity or stop/idle level.
module uart_tx_line_sel
    import uart_tx_pkg::*;
#(
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] sel,
    input  logic       data_bit,
    input  logic       par_bit,
    output logic       tx
);

    // Register the selected line level so the serial output never glitches.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx <= IDLE_LEVEL;
        end else begin
            case (sel)
                SEL_START: tx <= ~IDLE_LEVEL;
                SEL_DATA:  tx <= data_bit;
                SEL_PAR:   tx <= par_bit;
                SEL_STOP:  tx <= IDLE_LEVEL;
                default:   tx <= IDLE_LEVEL;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: start / LSB-first data / optional parity / 1-2 stop bits,
// paced by an external bit tick, with back-to-back frames on the final tick.
module uart_tx_frame_engine
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_tx_frame_engine_if.slave bus
);

    localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        bit_cnt_nxt;
    logic                    accept;
    logic                    frame_end;
    logic                    busy_q;
    logic                    ack_q;

    logic [DATA_WIDTH-1:0]   data_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    stop2_q;

    logic [1:0]              sel_nxt;
    logic                    data_bit_nxt;
    logic                    par_bit;

    // Next-state logic: advance one bit per tick, accept in idle or on the final tick.
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        accept      = 1'b0;
        frame_end   = 1'b0;
        case (state)
            S_IDLE: begin
                accept = bus.DATA_VALID;
            end
            S_START: begin
                if (bus.BIT_TICK) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            S_DATA: begin
                if (bus.BIT_TICK) begin
                    if (bit_cnt < LAST_BIT) begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end else if (par_en_q) begin
                        state_nxt = S_PARITY;
                    end else begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bus.BIT_TICK) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (bus.BIT_TICK) begin
                    if (stop2_q) begin
                        state_nxt = S_STOP2;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (bus.BIT_TICK) begin
                    frame_end = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (frame_end) begin
            accept    = bus.DATA_VALID;
            state_nxt = S_IDLE;
        end
        if (accept) begin
            state_nxt = S_START;
        end
    end

    // Line select follows the state being entered, so TX_OUT changes together with it.
    always_comb begin
        case (state_nxt)
            S_START:  sel_nxt = SEL_START;
            S_DATA:   sel_nxt = SEL_DATA;
            S_PARITY: sel_nxt = SEL_PAR;
            default:  sel_nxt = SEL_STOP;
        endcase
    end

    assign data_bit_nxt = data_q[bit_cnt_nxt];
    assign par_bit      = parity_bit(MAX_DATA_WIDTH'(data_q), par_typ_q);

    // State register, bit counter and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            busy_q  <= (state_nxt != S_IDLE);
            ack_q   <= accept;
        end
    end

    // Capture the word and its frame options on accept; inputs are free afterwards.
    // NOTE: shadow registers carry no reset; they are only read after an accept loads them.
    always_ff @(posedge CLK) begin
        if (accept) begin
            data_q    <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
            stop2_q   <= bus.STOP2;
        end
    end

    uart_tx_line_sel #(
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_line_sel (
        .CLK      (CLK),
        .RST      (RST),
        .sel      (sel_nxt),
        .data_bit (data_bit_nxt),
        .par_bit  (par_bit),
        .tx       (bus.TX_OUT)
    );

    assign bus.BUSY     = busy_q;
    assign bus.DATA_ACK = ack_q;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Self-checking bench for uart_tx_frame_engine: an 8-bit and a 9-bit build,
// compared against a frame model built from the line protocol rules.
module tb_uart_tx_frame_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       valid = 1'b0;
    logic [8:0] pdata = '0;
    logic       pen_in = 1'b0;
    logic       ptyp_in = 1'b0;
    logic       st2_in = 1'b0;
    logic       use9 = 1'b0;

    logic [8:0] nxt_data = '0;
    logic       nxt_pen = 1'b0;
    logic       nxt_ptyp = 1'b0;
    logic       nxt_st2 = 1'b0;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_frame_engine_if #(.DATA_WIDTH(8)) if8 ();
    uart_tx_frame_engine_if #(.DATA_WIDTH(9)) if9 ();

    assign if8.BIT_TICK   = tick;
    assign if8.P_DATA     = pdata[7:0];
    assign if8.DATA_VALID = valid & ~use9;
    assign if8.PAR_EN     = pen_in;
    assign if8.PAR_TYP    = ptyp_in;
    assign if8.STOP2      = st2_in;

    assign if9.BIT_TICK   = tick;
    assign if9.P_DATA     = pdata;
    assign if9.DATA_VALID = valid & use9;
    assign if9.PAR_EN     = pen_in;
    assign if9.PAR_TYP    = ptyp_in;
    assign if9.STOP2      = st2_in;

    uart_tx_frame_engine #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut8 (
        .CLK (clk),
        .RST (rst),
        .bus (if8)
    );

    uart_tx_frame_engine #(.DATA_WIDTH(9), .IDLE_LEVEL(1'b1)) dut9 (
        .CLK (clk),
        .RST (rst),
        .bus (if9)
    );

    logic tx_obs;
    logic busy_obs;
    logic ack_obs;
    assign tx_obs   = use9 ? if9.TX_OUT   : if8.TX_OUT;
    assign busy_obs = use9 ? if9.BUSY     : if8.BUSY;
    assign ack_obs  = use9 ? if9.DATA_ACK : if8.DATA_ACK;

    // Expected line bits of one frame, one entry per tick period.
    task automatic build_frame(input logic [8:0] d, input int dw, input bit pen,
                               input bit ptyp, input bit st2);
        int ones;
        ones  = 0;
        exp_q = {};
        exp_q.push_back(1'b0);
        for (int k = 0; k < dw; k++) begin
            exp_q.push_back(d[k]);
            if (d[k]) ones++;
        end
        if (pen) exp_q.push_back(bit'((ones % 2) ^ int'(ptyp)));
        exp_q.push_back(1'b1);
        if (st2) exp_q.push_back(1'b1);
    endtask

    task automatic start_word(input logic [8:0] d, input bit pen, input bit ptyp, input bit st2);
        pdata   = d;
        pen_in  = pen;
        ptyp_in = ptyp;
        st2_in  = st2;
        valid   = 1'b1;
        @(negedge clk);
    endtask

    // Called at the first negedge of a frame; walks every bit period and checks the line.
    task automatic play_frame(input logic [8:0] d, input bit pen, input bit ptyp, input bit st2,
                              input int gap, input bit chain, input int glitch_at, input int abort_at);
        int  dw;
        int  acks;
        bit  bad_tx;
        bit  bad_busy;
        logic got_tx;
        logic got_busy;
        dw = use9 ? 9 : 8;
        build_frame(d, dw, pen, ptyp, st2);
        acks = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            bad_tx   = 1'b0;
            bad_busy = 1'b0;
            got_tx   = 1'b0;
            got_busy = 1'b0;
            for (int c = 0; c < gap; c++) begin
                if (!bad_tx && tx_obs !== exp_q[i]) begin bad_tx = 1'b1; got_tx = tx_obs; end
                if (!bad_busy && busy_obs !== 1'b1) begin bad_busy = 1'b1; got_busy = busy_obs; end
                if (ack_obs === 1'b1) acks++;
                if (i == abort_at && c == 0) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    checks++;
                    if (tx_obs !== 1'b1) begin
                        errors++;
                        $display("FAIL abort_tx: TX_OUT=%b expected 1", tx_obs);
                    end
                    checks++;
                    if (busy_obs !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_busy: BUSY=%b expected 0", busy_obs);
                    end
                    checks++;
                    if (ack_obs !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_ack: DATA_ACK=%b expected 0", ack_obs);
                    end
                    return;
                end
                valid = chain || (i == glitch_at && c == 0);
                if (chain) begin
                    pdata   = nxt_data;
                    pen_in  = nxt_pen;
                    ptyp_in = nxt_ptyp;
                    st2_in  = nxt_st2;
                end else if (i == glitch_at && c == 0) begin
                    pdata   = 9'($urandom);
                    pen_in  = 1'($urandom);
                    ptyp_in = 1'($urandom);
                    st2_in  = 1'($urandom);
                end
                tick = (c == gap - 1);
                @(negedge clk);
            end
            tick = 1'b0;
            checks++;
            if (bad_tx) begin
                errors++;
                $display("FAIL frame_bit%0d (data=%h w=%0d): TX_OUT=%b expected %b", i, d, dw, got_tx, exp_q[i]);
            end
            checks++;
            if (bad_busy) begin
                errors++;
                $display("FAIL busy_bit%0d (data=%h): BUSY=%b expected 1", i, d, got_busy);
            end
        end
        valid = 1'b0;
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL ack_count (data=%h): %0d pulses, expected 1", d, acks);
        end
        if (!chain) begin
            checks++;
            if (busy_obs !== 1'b0) begin
                errors++;
                $display("FAIL end_busy (data=%h): BUSY=%b expected 0", d, busy_obs);
            end
            checks++;
            if (tx_obs !== 1'b1 || ack_obs !== 1'b0) begin
                errors++;
                $display("FAIL end_idle (data=%h): TX_OUT=%b DATA_ACK=%b expected 1/0", d, tx_obs, ack_obs);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (if8.TX_OUT !== 1'b1 || if9.TX_OUT !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: %b/%b expected 1/1", if8.TX_OUT, if9.TX_OUT);
        end
        checks++;
        if (if8.BUSY !== 1'b0 || if9.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: %b/%b expected 0/0", if8.BUSY, if9.BUSY);
        end
        checks++;
        if (if8.DATA_ACK !== 1'b0 || if9.DATA_ACK !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: %b/%b expected 0/0", if8.DATA_ACK, if9.DATA_ACK);
        end
        rst = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        checks++;
        if (if8.TX_OUT !== 1'b1 || if8.BUSY !== 1'b0 || if9.TX_OUT !== 1'b1 || if9.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick: tx=%b/%b busy=%b/%b expected 1/1 0/0",
                     if8.TX_OUT, if9.TX_OUT, if8.BUSY, if9.BUSY);
        end
    endtask

    task automatic test_8n1();
        use9 = 1'b0;
        start_word(9'h0A5, 1'b0, 1'b0, 1'b0);
        play_frame(9'h0A5, 1'b0, 1'b0, 1'b0, 16, 1'b0, -1, -1);
    endtask

    task automatic test_parity();
        use9 = 1'b0;
        start_word(9'h0A5, 1'b1, 1'b0, 1'b0);
        play_frame(9'h0A5, 1'b1, 1'b0, 1'b0, 4, 1'b0, -1, -1);
        start_word(9'h0A5, 1'b1, 1'b1, 1'b0);
        play_frame(9'h0A5, 1'b1, 1'b1, 1'b0, 3, 1'b0, -1, -1);
        start_word(9'h007, 1'b1, 1'b0, 1'b0);
        play_frame(9'h007, 1'b1, 1'b0, 1'b0, 2, 1'b0, -1, -1);
    endtask

    task automatic test_width9();
        use9 = 1'b1;
        start_word(9'h1FF, 1'b0, 1'b0, 1'b1);
        play_frame(9'h1FF, 1'b0, 1'b0, 1'b1, 3, 1'b0, -1, -1);
        start_word(9'h155, 1'b1, 1'b1, 1'b1);
        play_frame(9'h155, 1'b1, 1'b1, 1'b1, 1, 1'b0, -1, -1);
    endtask

    task automatic test_back_to_back();
        use9     = 1'b0;
        nxt_data = 9'h00F;
        nxt_pen  = 1'b0;
        nxt_ptyp = 1'b0;
        nxt_st2  = 1'b0;
        start_word(9'h055, 1'b0, 1'b0, 1'b0);
        play_frame(9'h055, 1'b0, 1'b0, 1'b0, 2, 1'b1, -1, -1);
        play_frame(9'h00F, 1'b0, 1'b0, 1'b0, 2, 1'b0, -1, -1);
    endtask

    task automatic test_midframe_ignore();
        use9 = 1'b0;
        start_word(9'h03C, 1'b1, 1'b1, 1'b0);
        play_frame(9'h03C, 1'b1, 1'b1, 1'b0, 3, 1'b0, 3, -1);
        use9 = 1'b1;
        start_word(9'h0C6, 1'b0, 1'b0, 1'b1);
        play_frame(9'h0C6, 1'b0, 1'b0, 1'b1, 2, 1'b0, 7, -1);
    endtask

    task automatic test_reset_abort();
        use9 = 1'b0;
        start_word(9'h0C3, 1'b0, 1'b0, 1'b0);
        play_frame(9'h0C3, 1'b0, 1'b0, 1'b0, 4, 1'b0, -1, 4);
        start_word(9'h09A, 1'b1, 1'b0, 1'b1);
        play_frame(9'h09A, 1'b1, 1'b0, 1'b1, 3, 1'b0, -1, -1);
    endtask

    task automatic test_random();
        logic [8:0] d;
        bit pen;
        bit ptyp;
        bit st2;
        int gap;
        for (int n = 0; n < 12; n++) begin
            use9 = 1'($urandom);
            d    = use9 ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 255));
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            st2  = 1'($urandom);
            gap  = int'($urandom_range(1, 5));
            start_word(d, pen, ptyp, st2);
            play_frame(d, pen, ptyp, st2, gap, 1'b0, (n % 3 == 0) ? 2 : -1, -1);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_width9();
        test_back_to_back();
        test_midframe_ignore();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
